mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit downstream of the ALU control decoder.
- Consumes the decoder's ALU control code for mult, multu, div and divu, and owns the architectural HI/LO registers.
- Provides busy for pipeline stall and a one-cycle done pulse.
- Also services mthi/mtlo writes.

---
 rtl/mult_div_unit_pkg.sv | 27 ++
 rtl/mult_div_unit_if.sv | 33 +++
 rtl/mult_div_unit_restoring_divider.sv | 82 ++++++++
 rtl/mult_div_unit.sv | 177 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mult_div_unit_pkg.sv
// mdu_pkg: definitions shared by the multiply/divide unit and the ALU control decoder.
//   ALU_MULT/ALU_MULTU/ALU_DIV/ALU_DIVU : 6-bit ALU control codes serviced by the unit
//   mdu_state_t                          : controller states (IDLE, MUL, DIV, FIXUP)
//   ITER_COUNT                           : iterations of the bit-serial multiply/divide
//   is_mdu_op()                          : true for any of the four codes above
package mdu_pkg;

    localparam logic [5:0] ALU_MULT  = 6'd15;
    localparam logic [5:0] ALU_MULTU = 6'd16;
    localparam logic [5:0] ALU_DIV   = 6'd17;
    localparam logic [5:0] ALU_DIVU  = 6'd18;

    localparam int ITER_COUNT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DIV   = 2'd2,
        FIXUP = 2'd3
    } mdu_state_t;

    function automatic logic is_mdu_op(input logic [5:0] code);
        return (code == ALU_MULT) || (code == ALU_MULTU) ||
               (code == ALU_DIV)  || (code == ALU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/response and HI/LO bundle of the multiply/divide unit.
//   master (pipeline side) drives start, alu_ctrl_in, op_a, op_b, hi_we, lo_we, wdata
//   slave  (unit side) drives busy, done, hi, lo and state_dbg (controller state)
// Handshake: start is only sampled while busy is low; once accepted, busy stays
// high until the result is written, and done pulses for exactly one cycle after
// HI/LO take the result. There is no backpressure on done.
interface mult_div_unit_if #(parameter int DATA_WIDTH = 32);
    import mdu_pkg::*;

    logic                  start;
    logic [5:0]            alu_ctrl_in;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  hi_we;
    logic                  lo_we;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    mdu_state_t            state_dbg;

    modport master (
        output start, alu_ctrl_in, op_a, op_b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo, state_dbg
    );

    modport slave (
        input  start, alu_ctrl_in, op_a, op_b, hi_we, lo_we, wdata,
        output busy, done, hi, lo, state_dbg
    );

endinterface

// File: rtl/mult_div_unit_restoring_divider.sv
// restoring_divider: unsigned bit-serial restoring divider, one quotient bit per cycle.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : load dividend/divisor and begin (one-cycle pulse)
//   dividend   : numerator magnitude
//   divisor    : denominator magnitude
//   done       : high during the cycle whose closing edge performs the final step
//   quotient   : quotient register (valid after the edge where done was high)
//   remainder  : remainder register (valid at the same time)
// Divide by zero is not special-cased here: it yields quotient all-ones and
// remainder equal to the dividend; the caller decides what to report.
module restoring_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;

    // 33-bit partial remainder: previous remainder shifted left with the next
    // dividend bit, which is taken from the top of the quotient register.
    logic [W:0] part;
    logic       ge;

    assign part      = {rem_q, quo_q[W-1]};
    assign ge        = (part >= {1'b0, dvs_q});
    assign done      = run_q && (cnt_q == CW'(W - 1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            // When the trial subtraction fails part < divisor, so its top bit is 0.
            rem_d = ge ? W'(part - {1'b0, dvs_q}) : part[W-1:0];
            quo_d = {quo_q[W-2:0], ge};
            cnt_d = cnt_q + CW'(1);
            if (done) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle mult/multu/div/divu unit owning the HI/LO registers.
//   clk, reset : clock, asynchronous active-high reset (clears everything)
//   bus        : mult_div_unit_if.slave - start/alu_ctrl_in/op_a/op_b request,
//                hi_we/lo_we/wdata for mthi/mtlo, busy/done/hi/lo/state_dbg out
// Operands are converted to magnitudes at the start edge; both cores run
// unsigned and the signs are re-applied in FIXUP before HI/LO are written.
// Build option FAST_MULT_EN: the multiply is a single native 64-bit product
// computed in one MUL cycle instead of 32 shift-add steps. Results match.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(ITER_COUNT);

    mdu_state_t       state_q, state_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;          // result sign (quotient/product)
    logic             rem_neg_q, rem_neg_d;  // remainder follows the dividend
    logic             div_zero_q, div_zero_d;
    logic [W-1:0]     a_raw_q, a_raw_d;      // original dividend for divide by zero
    logic [W-1:0]     mcand_q, mcand_d;
    logic [2*W-1:0]   prod_q, prod_d;        // {accumulator, remaining multiplier bits}
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic             done_q, done_d;
`ifndef FAST_MULT_EN
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W:0]       mul_sum;
`endif

    logic             op_valid, is_signed, is_div_op, a_neg, b_neg;
    logic [W-1:0]     a_mag, b_mag;
    logic             div_start, div_done;
    logic [W-1:0]     div_quo, div_rem, quo_fix, rem_fix;
    logic [2*W-1:0]   prod_fix;

    assign op_valid  = bus.start && is_mdu_op(bus.alu_ctrl_in);
    assign is_signed = (bus.alu_ctrl_in == ALU_MULT) || (bus.alu_ctrl_in == ALU_DIV);
    assign is_div_op = (bus.alu_ctrl_in == ALU_DIV)  || (bus.alu_ctrl_in == ALU_DIVU);
    assign a_neg     = is_signed && bus.op_a[W-1];
    assign b_neg     = is_signed && bus.op_b[W-1];
    assign a_mag     = a_neg ? -bus.op_a : bus.op_a;
    assign b_mag     = b_neg ? -bus.op_b : bus.op_b;
    assign div_start = (state_q == IDLE) && op_valid && is_div_op;

    restoring_divider #(.W(W)) u_div (
        .clk       (clk),
        .rst       (reset),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign quo_fix  = neg_q     ? -div_quo : div_quo;
    assign rem_fix  = rem_neg_q ? -div_rem : div_rem;
    assign prod_fix = neg_q     ? -prod_q  : prod_q;
`ifndef FAST_MULT_EN
    assign mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
`endif

    always_comb begin
        state_d    = state_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        a_raw_d    = a_raw_q;
        mcand_d    = mcand_q;
        prod_d     = prod_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
`ifndef FAST_MULT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (op_valid) begin
                    state_d    = is_div_op ? DIV : MUL;
                    is_div_d   = is_div_op;
                    neg_d      = a_neg ^ b_neg;
                    rem_neg_d  = a_neg;
                    div_zero_d = (bus.op_b == '0);
                    a_raw_d    = bus.op_a;
                    mcand_d    = a_mag;
                    prod_d     = {{W{1'b0}}, b_mag};
`ifndef FAST_MULT_EN
                    cnt_d      = '0;
`endif
                end
            end
            MUL: begin
`ifdef FAST_MULT_EN
                prod_d  = {{W{1'b0}}, mcand_q} * {{W{1'b0}}, prod_q[W-1:0]};
                state_d = FIXUP;
`else
                // Add the multiplicand if the current multiplier bit is set,
                // then shift the whole accumulator right by one.
                prod_d = {mul_sum, prod_q[W-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER_COUNT - 1)) state_d = FIXUP;
`endif
            end
            DIV: begin
                if (div_done) state_d = FIXUP;
            end
            FIXUP: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*W-1:W];
                    lo_d = prod_fix[W-1:0];
                end else if (div_zero_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            a_raw_q    <= '0;
            mcand_q    <= '0;
            prod_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
`ifndef FAST_MULT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            a_raw_q    <= a_raw_d;
            mcand_q    <= mcand_d;
            prod_q     <= prod_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
`ifndef FAST_MULT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit. Each accepted operation
// pushes its reference {HI,LO} and busy length; a monitor pops them on done.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clk;
    logic rst;

    mult_div_unit_if #(.DATA_WIDTH(32)) bus();

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

`ifdef FAST_MULT_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q[$];
    int          lat_q[$];
    int          busy_cnt = 0;
    logic        done_prev = 1'b0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    logic [31:0] pre_hi, pre_lo;

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural reference: {HI, LO} for one operation.
    function automatic logic [63:0] ref_model(input logic [5:0] code,
                                              input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     ia, ib, q, r;
        logic [63:0] ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ia = $signed(a);
        ib = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (code)
            ALU_MULT:  return 64'(sa * sb);
            ALU_MULTU: return ua * ub;
            ALU_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                q = ia / ib;
                r = ia % ib;
                return {32'(r), 32'(q)};
            end
            ALU_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [63:0] e;
        int          l;
        if (rst) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                chk("done_pulse_width", done_prev, 1'b0);
                chk("done_has_expectation", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    chk("hi_lo", {bus.hi, bus.lo}, e);
                    chk("busy_cycles", busy_cnt, l);
                end
                busy_cnt = 0;
            end
            done_prev = bus.done;
        end
    end

    // ---------------- driver tasks (entered/left on a negedge) ----------------
    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!bus.busy) return;
            @(negedge clk);
        end
        chk("idle_timeout", bus.busy, 1'b0);
    endtask

    task automatic issue(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic wr_hi, input logic [31:0] wd);
        logic [63:0] e;
        wait_idle();
        e      = ref_model(code, a, b);
        pre_hi = wr_hi ? wd : model_hi;
        pre_lo = model_lo;
        bus.start       = 1'b1;
        bus.alu_ctrl_in = code;
        bus.op_a        = a;
        bus.op_b        = b;
        bus.hi_we       = wr_hi;
        bus.wdata       = wd;
        exp_q.push_back(e);
        lat_q.push_back((code == ALU_DIV || code == ALU_DIVU) ? DIV_LAT : MUL_LAT);
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
        chk("busy_after_start", bus.busy, 1'b1);
        chk("hi_during_op", bus.hi, pre_hi);
        chk("lo_during_op", bus.lo, pre_lo);
        model_hi = e[63:32];
        model_lo = e[31:0];
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0]  codes[4];
        logic [31:0] wd;
        codes = '{ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};

        rst = 1'b1;
        bus.start = 1'b0; bus.alu_ctrl_in = '0; bus.op_a = '0; bus.op_b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_done", bus.done, 1'b0);
        chk("reset_state", bus.state_dbg, IDLE);
        #2 rst = 1'b0;
        @(negedge clk);

        // Directed operations
        issue(ALU_MULT,  32'hFFFFFFFE, 32'd3, 1'b0, '0);
        issue(ALU_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, '0);
        issue(ALU_DIV,   32'hFFFFFFF9, 32'd2, 1'b0, '0);
        issue(ALU_DIVU,  32'd7,        32'd2, 1'b0, '0);
        issue(ALU_DIV,   32'h00001234, 32'd0, 1'b0, '0);
        issue(ALU_DIVU,  32'hDEADBEEF, 32'd0, 1'b0, '0);
        issue(ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, '0);
        issue(ALU_MULT,  32'h80000000, 32'h80000000, 1'b0, '0);
        // start together with mthi in IDLE: write lands, result overwrites later
        issue(ALU_DIV,   32'd100, 32'hFFFFFFFD, 1'b1, 32'h13572468);

        // start and mthi/mtlo while busy, held through FIXUP: all ignored
        issue(ALU_DIVU, 32'd1000, 32'd7, 1'b0, '0);
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.alu_ctrl_in = ALU_MULT; bus.op_a = 32'd5; bus.op_b = 32'd6;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5A5A5;
        @(negedge clk);
        bus.start = 1'b0;
        chk("hi_we_busy_ignored", bus.hi, pre_hi);
        chk("lo_we_busy_ignored", bus.lo, pre_lo);
        wait_idle();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;

        // Invalid code: no action
        @(negedge clk);
        bus.start = 1'b1; bus.alu_ctrl_in = 6'd3; bus.op_a = 32'd9; bus.op_b = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        chk("invalid_code_busy", bus.busy, 1'b0);
        chk("invalid_code_hi", bus.hi, model_hi);

        // Reset in the middle of a divide: no done, HI/LO cleared at once
        bus.start = 1'b1; bus.alu_ctrl_in = ALU_DIV; bus.op_a = $urandom; bus.op_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_busy", bus.busy, 1'b0);
        chk("midreset_hi", bus.hi, 32'd0);
        chk("midreset_lo", bus.lo, 32'd0);
        chk("midreset_done", bus.done, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        model_hi = '0;
        model_lo = '0;

        // mtlo in IDLE
        wd = $urandom;
        bus.lo_we = 1'b1; bus.wdata = wd;
        @(negedge clk);
        bus.lo_we = 1'b0;
        chk("mtlo_lo", bus.lo, wd);
        chk("mtlo_hi", bus.hi, 32'd0);
        chk("mtlo_done", bus.done, 1'b0);
        model_lo = wd;
        repeat (3) @(negedge clk);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            issue(codes[$urandom_range(0, 3)], pick_operand(), pick_operand(),
                  1'($urandom_range(0, 1)), $urandom);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
